// File: rtl/mips_clk_pkg.sv
// Shared definitions for the MIPS single-cycle phase clock generator.
//   phase_e          : FSM states; the four phase states time one processor cycle
//   DEF_*_TICKS      : default clock periods spent in each phase
//   max4()           : largest of four tick counts, used to size the phase timer
package mips_clk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PC   = 3'd1,
    ST_INST = 3'd2,
    ST_DATA = 3'd3,
    ST_REG  = 3'd4,
    ST_DONE = 3'd5
  } phase_e;

  localparam int DEF_PC_TICKS   = 1;
  localparam int DEF_INST_TICKS = 5;
  localparam int DEF_DATA_TICKS = 5;
  localparam int DEF_REG_TICKS  = 1;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/mips_phase_timer.sv
// Loadable down-counter that times one phase of the clock generator.
//   clock    : rising-edge clock
//   reset    : synchronous active-high reset, clears the counter
//   load     : load load_val this edge (takes priority over counting)
//   load_val : periods remaining after the first one (phase length - 1)
//   last     : high during the final period of the current phase
module mips_phase_timer #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      // Parks at zero while idle so no wrap-around can occur.
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/mips_phase_clockgen.sv
// Phase clock generator for a single-cycle MIPS core: sequences pc, instruction
// memory, data memory and register-bank strobes, one phase at a time.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   run               : level, keep issuing processor cycles while high
//   step              : one-clock pulse, request a single processor cycle
//   max_cycles        : stop in DONE when cycle_count reaches it (0 = no limit)
//   pc_clock .. reg_clock : registered phase strobes, at most one high
//   cycle_count       : completed processor cycles (wraps at 2^32)
//   busy              : a processor cycle is in progress
//   done              : cycle limit reached; held until reset
module mips_phase_clockgen
  import mips_clk_pkg::*;
#(
  parameter int PC_TICKS   = DEF_PC_TICKS,
  parameter int INST_TICKS = DEF_INST_TICKS,
  parameter int DATA_TICKS = DEF_DATA_TICKS,
  parameter int REG_TICKS  = DEF_REG_TICKS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic [31:0] max_cycles,
  output logic        pc_clock,
  output logic        inst_clock,
  output logic        data_clock,
  output logic        reg_clock,
  output logic [31:0] cycle_count,
  output logic        busy,
  output logic        done
);

  localparam int MAX_T  = max4(PC_TICKS, INST_TICKS, DATA_TICKS, REG_TICKS);
  localparam int TICK_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  if (PC_TICKS < 1 || INST_TICKS < 1 || DATA_TICKS < 1 || REG_TICKS < 1) begin : g_bad_ticks
    $fatal(1, "mips_phase_clockgen: every *_TICKS parameter must be >= 1");
  end

  phase_e              state_q, state_d;
  logic [31:0]         cycle_count_q, cycle_count_d;
  logic                pc_clock_q, pc_clock_d;
  logic                inst_clock_q, inst_clock_d;
  logic                data_clock_q, data_clock_d;
  logic                reg_clock_q, reg_clock_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tick_load;
  logic [TICK_W-1:0]   tick_load_val;
  logic                tick_last;

  mips_phase_timer #(
    .W (TICK_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tick_load),
    .load_val (tick_load_val),
    .last     (tick_last)
  );

  // Next-state logic: the timer is reloaded on every phase entry, so each
  // phase lasts exactly its tick count. run/step are only looked at in IDLE
  // and on the final REG period.
  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    tick_load     = 1'b0;
    tick_load_val = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (run || step) begin
          state_d       = ST_PC;
          tick_load     = 1'b1;
          tick_load_val = TICK_W'(PC_TICKS - 1);
        end
      end
      ST_PC: begin
        if (tick_last) begin
          state_d       = ST_INST;
          tick_load     = 1'b1;
          tick_load_val = TICK_W'(INST_TICKS - 1);
        end
      end
      ST_INST: begin
        if (tick_last) begin
          state_d       = ST_DATA;
          tick_load     = 1'b1;
          tick_load_val = TICK_W'(DATA_TICKS - 1);
        end
      end
      ST_DATA: begin
        if (tick_last) begin
          state_d       = ST_REG;
          tick_load     = 1'b1;
          tick_load_val = TICK_W'(REG_TICKS - 1);
        end
      end
      ST_REG: begin
        if (tick_last) begin
          cycle_count_d = cycle_count_q + 32'd1;
          // Equality on the new count only: a limit already passed is not
          // seen again until the counter wraps.
          if (max_cycles != 32'd0 && cycle_count_d == max_cycles) begin
            state_d = ST_DONE;
          end else if (run) begin
            state_d       = ST_PC;
            tick_load     = 1'b1;
            tick_load_val = TICK_W'(PC_TICKS - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each strobe
  // is glitch-free and aligned exactly with its phase.
  always_comb begin
    pc_clock_d   = (state_d == ST_PC);
    inst_clock_d = (state_d == ST_INST);
    data_clock_d = (state_d == ST_DATA);
    reg_clock_d  = (state_d == ST_REG);
    busy_d       = (state_d == ST_PC) || (state_d == ST_INST) ||
                   (state_d == ST_DATA) || (state_d == ST_REG);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cycle_count_q <= '0;
      pc_clock_q    <= 1'b0;
      inst_clock_q  <= 1'b0;
      data_clock_q  <= 1'b0;
      reg_clock_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      pc_clock_q    <= pc_clock_d;
      inst_clock_q  <= inst_clock_d;
      data_clock_q  <= data_clock_d;
      reg_clock_q   <= reg_clock_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign pc_clock    = pc_clock_q;
  assign inst_clock  = inst_clock_q;
  assign data_clock  = data_clock_q;
  assign reg_clock   = reg_clock_q;
  assign cycle_count = cycle_count_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mips_phase_clockgen.sv
// Scoreboard bench for mips_phase_clockgen with default tick counts (1/5/5/1).
// The stimulus side pushes the expected outputs for the period following each
// rising edge; a monitor pops and compares one entry on every falling edge.
module tb_mips_phase_clockgen;

  localparam int PCT = 1;
  localparam int IT  = 5;
  localparam int DT  = 5;
  localparam int RT  = 1;
  localparam int CYC = PCT + IT + DT + RT;

  typedef struct packed {
    logic        pc;
    logic        inst;
    logic        data;
    logic        rg;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run   = 1'b0;
  logic        step  = 1'b0;
  logic [31:0] max_cycles = 32'd0;
  logic        pc_clock, inst_clock, data_clock, reg_clock, busy, done;
  logic [31:0] cycle_count;

  int    errors = 0;
  int    checks = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  mips_phase_clockgen dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .max_cycles  (max_cycles),
    .pc_clock    (pc_clock),
    .inst_clock  (inst_clock),
    .data_clock  (data_clock),
    .reg_clock   (reg_clock),
    .cycle_count (cycle_count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // Expected outputs at offset o (0..CYC-1) of a processor cycle.
  function automatic exp_t at(input int o, input logic [31:0] cnt);
    exp_t e;
    e = '0;
    if (o < PCT)                e.pc   = 1'b1;
    else if (o < PCT + IT)      e.inst = 1'b1;
    else if (o < PCT + IT + DT) e.data = 1'b1;
    else                        e.rg   = 1'b1;
    e.busy = 1'b1;
    e.cnt  = cnt;
    return e;
  endfunction

  function automatic exp_t idle(input logic [31:0] cnt);
    exp_t e;
    e = '0;
    e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t fin(input logic [31:0] cnt);
    exp_t e;
    e = '0;
    e.done = 1'b1;
    e.cnt  = cnt;
    return e;
  endfunction

  task automatic cyc(input logic r, input logic s, input logic rs, input exp_t e, input string tag);
    run   = r;
    step  = s;
    reset = rs;
    @(posedge clock);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
  endtask

  task automatic phases(input int from, input int to, input logic [31:0] cnt,
                        input logic r, input logic s, input string tag);
    for (int o = from; o <= to; o++) cyc(r, s, 1'b0, at(o, cnt), tag);
  endtask

  // Monitor: compare outputs mid-period against the scoreboard.
  always @(negedge clock) begin
    exp_t  e;
    exp_t  act;
    string t;
    act = {pc_clock, inst_clock, data_clock, reg_clock, busy, done, cycle_count};
    checks++;
    if (!$onehot0({pc_clock, inst_clock, data_clock, reg_clock})) begin
      errors++;
      $display("FAIL strobe_overlap @%0t: got strobes=%b, required at most one high",
               $time, {pc_clock, inst_clock, data_clock, reg_clock});
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s @%0t: got pc=%b inst=%b data=%b reg=%b busy=%b done=%b cnt=%h, required pc=%b inst=%b data=%b reg=%b busy=%b done=%b cnt=%h",
                 t, $time, act.pc, act.inst, act.data, act.rg, act.busy, act.done, act.cnt,
                 e.pc, e.inst, e.data, e.rg, e.busy, e.done, e.cnt);
      end
    end
  end

  initial begin
    // Reset state
    cyc(1'b0, 1'b0, 1'b1, idle(32'd0), "reset");
    cyc(1'b0, 1'b0, 1'b1, idle(32'd0), "reset");
    cyc(1'b0, 1'b0, 1'b0, idle(32'd0), "idle_after_reset");

    // Free run: three back-to-back cycles, then run drops.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b0, at(0, k), "run_pc");
      phases(1, CYC - 1, k, 1'b1, 1'b0, "run_phase");
    end
    cyc(1'b0, 1'b0, 1'b0, idle(32'd3), "run_stop_idle");
    cyc(1'b0, 1'b0, 1'b0, idle(32'd3), "run_stop_idle");

    // Single step; step pulses during the cycle are ignored.
    cyc(1'b0, 1'b0, 1'b1, idle(32'd0), "step_reset");
    cyc(1'b0, 1'b1, 1'b0, at(0, 32'd0), "step_pc");
    phases(1, 3, 32'd0, 1'b0, 1'b0, "step_phase");
    phases(4, 5, 32'd0, 1'b0, 1'b1, "step_ignored");
    phases(6, CYC - 1, 32'd0, 1'b0, 1'b0, "step_phase");
    cyc(1'b0, 1'b0, 1'b0, idle(32'd1), "step_end_idle");

    // step and run together start one cycle; run decides continuation.
    cyc(1'b1, 1'b1, 1'b0, at(0, 32'd1), "both_pc");
    phases(1, CYC - 1, 32'd1, 1'b0, 1'b0, "both_phase");
    cyc(1'b0, 1'b0, 1'b0, idle(32'd2), "both_end_idle");

    // run dropped during INST of cycle 2: cycle 2 still completes.
    cyc(1'b0, 1'b0, 1'b1, idle(32'd0), "drop_reset");
    cyc(1'b1, 1'b0, 1'b0, at(0, 32'd0), "drop_pc1");
    phases(1, CYC - 1, 32'd0, 1'b1, 1'b0, "drop_c1");
    cyc(1'b1, 1'b0, 1'b0, at(0, 32'd1), "drop_pc2");
    cyc(1'b1, 1'b0, 1'b0, at(1, 32'd1), "drop_inst2");
    phases(2, CYC - 1, 32'd1, 1'b0, 1'b0, "drop_c2");
    cyc(1'b0, 1'b0, 1'b0, idle(32'd2), "drop_end_idle");

    // Reset during DATA overrides run, then restart from zero.
    cyc(1'b1, 1'b0, 1'b0, at(0, 32'd2), "mid_pc");
    phases(1, 7, 32'd2, 1'b1, 1'b0, "mid_phase");
    cyc(1'b1, 1'b0, 1'b1, idle(32'd0), "mid_reset");
    cyc(1'b1, 1'b0, 1'b0, at(0, 32'd0), "mid_restart_pc");
    phases(1, CYC - 1, 32'd0, 1'b1, 1'b0, "mid_restart");
    cyc(1'b0, 1'b0, 1'b0, idle(32'd1), "mid_restart_idle");

    // Cycle limit of 8: DONE after 96 clocks, then absorbing.
    max_cycles = 32'd8;
    cyc(1'b0, 1'b0, 1'b1, idle(32'd0), "lim_reset");
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b0, 1'b0, at(0, k), "lim_pc");
      phases(1, CYC - 1, k, 1'b1, 1'b0, "lim_phase");
    end
    cyc(1'b1, 1'b0, 1'b0, fin(32'd8), "lim_done");
    cyc(1'b1, 1'b1, 1'b0, fin(32'd8), "done_hold");
    cyc(1'b0, 1'b1, 1'b0, fin(32'd8), "done_hold");
    cyc(1'b1, 1'b0, 1'b0, fin(32'd8), "done_hold");
    cyc(1'b0, 1'b0, 1'b1, idle(32'd0), "done_reset");

    // Limit set below the current count is never matched.
    max_cycles = 32'd0;
    cyc(1'b1, 1'b0, 1'b0, at(0, 32'd0), "low_pc1");
    phases(1, CYC - 1, 32'd0, 1'b1, 1'b0, "low_c1");
    cyc(1'b1, 1'b0, 1'b0, at(0, 32'd1), "low_pc2");
    max_cycles = 32'd1;
    phases(1, CYC - 1, 32'd1, 1'b1, 1'b0, "low_c2");
    cyc(1'b0, 1'b0, 1'b0, idle(32'd2), "low_no_done");

    // Counter wrap from 0xFFFFFFFF with no limit.
    max_cycles = 32'd0;
    cyc(1'b0, 1'b0, 1'b1, idle(32'd0), "wrap_reset");
    cyc(1'b0, 1'b0, 1'b0, idle(32'd0), "wrap_idle");
    @(negedge clock);
    #1;
    force dut.cycle_count_q = 32'hFFFF_FFFF;
    cyc(1'b0, 1'b0, 1'b0, idle(32'hFFFF_FFFF), "wrap_preload");
    release dut.cycle_count_q;
    cyc(1'b0, 1'b1, 1'b0, at(0, 32'hFFFF_FFFF), "wrap_pc");
    phases(1, CYC - 1, 32'hFFFF_FFFF, 1'b0, 1'b0, "wrap_phase");
    cyc(1'b0, 1'b0, 1'b0, idle(32'd0), "wrap_zero");
    cyc(1'b0, 1'b0, 1'b0, idle(32'd0), "wrap_zero");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
